vfreq_meter: RTL and testbench

//  Measures the divided waveform produced by the programmable divider stage (its signal output).

---
 rtl/vfreq_meter.sv | 126 ++++++++++++
 tb/tb_vfreq_meter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vfreq_meter.sv
// rtl/vfreq_meter.sv - gated edge counter and period meter for the divider output
//
// Measures the divided waveform on sig_in: rising edges per fixed gate window
// (frequency) and clk cycles between consecutive rising edges (period).
// Both results are latched and announced by one-cycle valid strobes.
//
// Ports:
//   clk          - single clock, all logic on posedge
//   reset        - synchronous, active-high
//   en           - measurement enable; low holds counters cleared
//   sig_in       - divided waveform, asynchronous to clk
//   freq_count   - rising edges counted in the last completed gate window
//   freq_ovf     - last window's edge count saturated
//   freq_valid   - one-cycle strobe, freq_count/freq_ovf updated
//   period       - clk cycles between the last two rising edges
//   period_valid - one-cycle strobe, period updated
//   busy         - a gate window is in progress
module vfreq_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_ovf,
    output logic             freq_valid,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             busy
);

    localparam int TW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TW-1:0]    TIMER_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   s_prev;
    logic                   rise;

    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] edge_cnt;
    logic             win_ovf;
    logic [CNT_W-1:0] period_cnt;
    logic             seen_first;
    logic             edge_sat;
    logic             gate_last;

    // The synchronizer runs even while disabled so that enabling never
    // exposes a stale level as a fresh edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff <= '0;
            s_prev  <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], sig_in};
            s_prev  <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign rise      = sync_ff[SYNC_STAGES-1] & ~s_prev;
    assign edge_sat  = (edge_cnt == CNT_MAX);
    assign gate_last = (timer == TIMER_LAST);
    assign busy      = en & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer        <= '0;
            edge_cnt     <= '0;
            win_ovf      <= 1'b0;
            period_cnt   <= '0;
            seen_first   <= 1'b0;
            freq_count   <= '0;
            freq_ovf     <= 1'b0;
            freq_valid   <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            freq_valid   <= 1'b0;
            period_valid <= 1'b0;
            if (!en) begin
                // Disabled: discard any partial window and disarm the period
                // measurement; latched results keep their last values.
                timer      <= '0;
                edge_cnt   <= '0;
                win_ovf    <= 1'b0;
                period_cnt <= '0;
                seen_first <= 1'b0;
            end else begin
                if (gate_last) begin
                    // A rise in the terminal cycle still belongs to this window.
                    freq_count <= edge_cnt + CNT_W'(rise & ~edge_sat);
                    freq_ovf   <= win_ovf | (rise & edge_sat);
                    freq_valid <= 1'b1;
                    timer      <= '0;
                    edge_cnt   <= '0;
                    win_ovf    <= 1'b0;
                end else begin
                    timer <= timer + TW'(1);
                    if (rise) begin
                        if (edge_sat) begin
                            win_ovf <= 1'b1;
                        end else begin
                            edge_cnt <= edge_cnt + CNT_W'(1);
                        end
                    end
                end

                if (rise) begin
                    // The first edge after enable only arms the measurement.
                    if (seen_first) begin
                        period       <= period_cnt;
                        period_valid <= 1'b1;
                    end
                    period_cnt <= CNT_W'(1);
                    seen_first <= 1'b1;
                end else if (period_cnt != CNT_MAX) begin
                    period_cnt <= period_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vfreq_meter.sv
// tb/tb_vfreq_meter.sv - scoreboard bench for vfreq_meter
module tb_vfreq_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;
    logic en = 1'b0, sig_in = 1'b0;
    logic en2 = 1'b0, sig2 = 1'b0;

    logic [15:0] freq_count, period;
    logic        freq_ovf, freq_valid, period_valid, busy;
    logic [3:0]  s_freq_count, s_period;
    logic        s_freq_ovf, s_freq_valid, s_period_valid, s_busy;

    vfreq_meter dut (
        .clk(clk), .reset(reset), .en(en), .sig_in(sig_in),
        .freq_count(freq_count), .freq_ovf(freq_ovf), .freq_valid(freq_valid),
        .period(period), .period_valid(period_valid), .busy(busy)
    );

    vfreq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) dut_small (
        .clk(clk), .reset(reset), .en(en2), .sig_in(sig2),
        .freq_count(s_freq_count), .freq_ovf(s_freq_ovf), .freq_valid(s_freq_valid),
        .period(s_period), .period_valid(s_period_valid), .busy(s_busy)
    );

    typedef struct { int cnt; int ovf; int at; } fexp_t;
    typedef struct { int val; int at; } pexp_t;
    fexp_t fq[$];
    pexp_t pq[$];

    int n_chk  = 0;
    int n_fail = 0;
    int last_fc  = 0;
    int last_per = 0;
    int dut_sum  = 0;
    int model_sum = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit pulse_at(int i, int step_a, int switch_at, int step_b, int offset);
        if (i < switch_at)
            return (step_a != 0) && (i >= offset) && (((i - offset) % step_a) == 0);
        return (step_b != 0) && (((i - switch_at) % step_b) == 0);
    endfunction

    // Synchronous reset for one cycle; released right after the sampling edge
    // so the next edge is the first one with reset low.
    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        sig_in = 1'b0;
        sig2   = 1'b0;
        @(posedge clk);
        #1;
        check("rst_freq_count", 32'(freq_count), 0);
        check("rst_freq_ovf", 32'(freq_ovf), 0);
        check("rst_freq_valid", 32'(freq_valid), 0);
        check("rst_period", 32'(period), 0);
        check("rst_period_valid", 32'(period_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_small", {s_freq_count, s_period, s_freq_ovf, s_freq_valid, s_period_valid, s_busy}, 0);
        reset    = 1'b0;
        last_fc  = 0;
        last_per = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            en = 1'b0; en2 = 1'b0; sig_in = 1'b0; sig2 = 1'b0;
            @(posedge clk);
            #1;
            check("idle_strobes", {freq_valid, period_valid, s_freq_valid, s_period_valid}, 0);
        end
        check("idle_freq_hold", 32'(freq_count), last_fc);
        check("idle_period_hold", 32'(period), last_per);
        check("idle_busy", 32'(busy), 0);
    endtask

    // One continuous enabled segment. A pulse driven in cycle i is sampled at
    // edge i and becomes a counted rise at edge i+2; the gate window w covers
    // edges w*gate .. (w+1)*gate-1 counted from the first enabled edge.
    task automatic run_seg(input int which, input int len, input int step_a,
                           input int switch_at, input int step_b, input int offset);
        int gate, maxv, nwin, prev_t, t;
        int cnts[];
        fexp_t fe;
        pexp_t pe;
        logic fv, fo;
        logic [31:0] fc;
        gate   = which ? 100 : 1000;
        maxv   = which ? 15 : 65535;
        nwin   = len / gate;
        prev_t = -1;
        cnts   = new[nwin];
        foreach (cnts[w]) cnts[w] = 0;
        for (int i = 0; i < len; i++) begin
            if (pulse_at(i, step_a, switch_at, step_b, offset) && (i + 2 < len)) begin
                t = i + 2;
                if (t / gate < nwin) begin
                    cnts[t / gate]++;
                    model_sum++;
                end
                if (which == 0) begin
                    if (prev_t >= 0) begin
                        pe.val = (t - prev_t > maxv) ? maxv : t - prev_t;
                        pe.at  = t;
                        pq.push_back(pe);
                    end
                    prev_t = t;
                end
            end
        end
        for (int w = 0; w < nwin; w++) begin
            fe.cnt = (cnts[w] > maxv) ? maxv : cnts[w];
            fe.ovf = (cnts[w] > maxv) ? 1 : 0;
            fe.at  = (w + 1) * gate - 1;
            fq.push_back(fe);
        end

        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (which == 0) begin
                en = 1'b1; sig_in = pulse_at(i, step_a, switch_at, step_b, offset);
            end else begin
                en2 = 1'b1; sig2 = pulse_at(i, step_a, switch_at, step_b, offset);
            end
            @(posedge clk);
            #1;
            if (i == 0 && which == 0) check("busy", 32'(busy), 1);
            fv = which ? s_freq_valid : freq_valid;
            fc = which ? 32'(s_freq_count) : 32'(freq_count);
            fo = which ? s_freq_ovf : freq_ovf;
            if (fv) begin
                if (fq.size() == 0) begin
                    check("freq_unexpected", i, 32'hFFFF_FFFF);
                end else begin
                    fe = fq.pop_front();
                    check("freq_at", i, fe.at);
                    check("freq_count", fc, fe.cnt);
                    check("freq_ovf", 32'(fo), fe.ovf);
                    if (which == 0) last_fc = fe.cnt;
                    dut_sum += fc;
                end
            end
            if (which == 0 && period_valid) begin
                if (pq.size() == 0) begin
                    check("period_unexpected", i, 32'hFFFF_FFFF);
                end else begin
                    pe = pq.pop_front();
                    check("period_at", i, pe.at);
                    check("period", 32'(period), pe.val);
                    last_per = pe.val;
                end
            end
        end
        check("freq_missing", fq.size(), 0);
        check("period_missing", pq.size(), 0);
        fq.delete();
        pq.delete();
    endtask

    initial begin
        do_reset();
        idle(5);

        // constant low for three windows: zero counts, no period
        run_seg(0, 3000, 0, 3000, 0, 0);
        idle(5);

        // pulse every 10 clk: 100 edges per window, period 10
        run_seg(0, 3000, 10, 3000, 0, 0);
        idle(5);

        // edge landing on the terminal cycle; window totals must add up
        dut_sum = 0; model_sum = 0;
        run_seg(0, 2000, 7, 2000, 0, 3);
        check("window_sum", dut_sum, model_sum);
        idle(5);

        // enable dropped at timer=500, restored 20 cycles later
        run_seg(0, 500, 10, 500, 0, 0);
        idle(20);
        run_seg(0, 1100, 10, 1100, 0, 5);
        idle(5);

        // reset for one cycle in the middle of the second window
        run_seg(0, 1500, 10, 1500, 0, 0);
        do_reset();
        run_seg(0, 1100, 10, 1100, 0, 0);
        idle(5);

        // small instance: saturation then normal count
        run_seg(1, 200, 2, 98, 10, 0);
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
